pulse_burst_ctrl: RTL and testbench
===================================

Name: pulse_burst_ctrl

Overview:
Sequencer for the pulse-generation datapath. It accepts pulse-burst commands (period, high width, pulse count) over a valid/ready handshake and drives a single pulse output. A one-deep pending register allows back-to-back bursts with no gap cycle. Upstream control logic or a CPU-register block uses it to schedule runtime-programmable pulse trains in place of fixed-parameter generators.

Parameters:
PW, 16, width of the period and width fields and of the phase counter
CW, 16, width of the pulse-count field and of the remaining-pulse counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_period  in  PW  pulse period in clk cycles (0 treated as 1)
cmd_width  in  PW  high cycles per period
cmd_count  in  CW  number of periods in the burst
abort  in  1  cancel the running burst and the pending command
pul_out  out  1  registered pulse output
busy  out  1  burst running
done  out  1  one-cycle strobe: burst completed normally
pulses_left  out  CW  periods remaining, including the current one; 0 when idle

Behaviour:
- Reset values:
  - pul_out=0, busy=0, done=0, pulses_left=0.
  - cmd_ready=1 once rst is deasserted.
  - State IDLE; pending slot empty.
- States:
  - IDLE: no burst running.
  - RUN: registers phase (PW bits) and rem (CW bits) are active.
- cmd_ready:
  - Equals !pending_full && !abort.
  - A handshake is cmd_valid&&cmd_ready at a rising edge.
- Accept in IDLE (count>0):
  - At the same edge: state=RUN, phase=0, rem=count, busy=1, pul_out=(0<width).
  - pul_out reflects phase 0 in the cycle after the handshake cycle (latency 1).
- Accept in RUN: the command is stored in the pending slot, and cmd_ready drops.
- Output in RUN: for each cycle at phase p, pul_out=1 iff p<width.
  - width=0 gives a constant low burst.
  - width>=period gives a constant high burst.
- Phase counting:
  - Phase increments each cycle and wraps to 0 after period-1.
  - On wrap, rem decrements.
- Burst end: at the edge leaving phase period-1 with rem==1.
  - If the pending slot is full: load the pending command (phase=0), empty the slot, done=1 for one cycle. There is no idle cycle between bursts.
  - Else, if a handshake occurs at that same edge: the new command starts directly (bypass), done=1.
  - Else: state=IDLE, pul_out=0, busy=0, pulses_left=0, done=1.
- count=0 command:
  - Accepted, emits no pulses, and does not change state.
  - If IDLE, done=1 in the next cycle.
  - If queued behind a burst, it is discarded at load time, done=1 once for the preceding burst only, then the controller goes IDLE.
- period=0 is treated as period=1 (every cycle is phase 0).
- abort (priority over everything except rst):
  - Next edge: IDLE, pending emptied, pul_out=0, busy=0, pulses_left=0, done=0.
  - Any command presented in the abort cycle is not accepted.
- rst mid-burst: same outcome as abort; all outputs return to reset values at the next edge.
- pulses_left is rem, registered.
- All arithmetic is unsigned; counters never exceed their field widths.

Decomposition:
- Package pulse_pkg:
  - state enum {IDLE, RUN}.
  - Command struct {period, width, count} parameterised by PW/CW via localparams.
  - Constant PERIOD_MIN=1.
- One natural sub-module, pulse_phase_cnt:
  - Phase counter with wrap and a compare against width.
  - Outputs: pul_next and a wrap strobe.
  - The controller owns the handshake, the pending slot, rem and done.

Test Plan:
- rst, then cmd{period=4,width=2,count=3} in IDLE -> pul_out pattern 1100 1100 1100 starting the cycle after the handshake; done high exactly one cycle after the 12th output cycle; busy high 12 cycles.
- cmd A{4,1,2} then cmd B{3,3,1} offered during A -> B queued, cmd_ready=0 until B loads; output 1000 1000 111 with no gap; done strobes at the end of A and at the end of B.
- cmd{period=0,width=0,count=5} and cmd{period=5,width=7,count=1} -> first gives 5 low cycles; second gives 5 high cycles; done after each.
- cmd{8,4,10} with abort at the 3rd cycle of period 2, plus a pending cmd -> pul_out=0, busy=0, pulses_left=0 next edge; no done; pending discarded; cmd_ready=0 during the abort cycle.
- cmd count=0 in IDLE -> pul_out stays 0, done=1 next cycle; the same command queued behind {2,1,1} -> a single done, then IDLE.
- rst asserted mid-burst with cmd_valid high -> all outputs at reset values next edge; the command is accepted only after rst is deasserted.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse-burst sequencer.
package pulse_pkg;
    localparam int PKG_PW     = 16;
    localparam int PKG_CW     = 16;
    localparam int PERIOD_MIN = 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [PKG_PW-1:0] period;
        logic [PKG_PW-1:0] width;
        logic [PKG_CW-1:0] count;
    } pulse_cmd_t;
endpackage

// File: rtl/pulse_phase_cnt.sv
// Phase counter for one burst: wraps after period-1 and predicts the next pulse level.
module pulse_phase_cnt
    import pulse_pkg::*;
#(
    parameter int PW = PKG_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic          advance,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] width,
    output logic          wrap,
    output logic          pul_next
);
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_d;
    logic [PW-1:0] last_phase;

    // A zero period behaves like period 1: every cycle is phase 0.
    assign last_phase = (period == '0) ? '0 : period - PW'(PERIOD_MIN);
    assign wrap       = (phase >= last_phase);

    always_comb begin
        phase_d = phase;
        if (clear || load)
            phase_d = '0;
        else if (advance)
            phase_d = wrap ? '0 : phase + PW'(1);
    end

    // Level for the phase about to be entered, so pul_out registers in step.
    assign pul_next = (phase_d < width);

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else
            phase <= phase_d;
    end
endmodule

// File: rtl/pulse_burst_ctrl.sv
// Pulse-burst sequencer: valid/ready command intake, one-deep pending slot, registered pulse output.
module pulse_burst_ctrl
    import pulse_pkg::*;
#(
    parameter int PW = PKG_PW,
    parameter int CW = PKG_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [PW-1:0] cmd_period,
    input  logic [PW-1:0] cmd_width,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    output logic          pul_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulses_left
);
    state_t        state;
    pulse_cmd_t    in_cmd, pend, ld_cmd;
    logic          pend_full;
    logic [PW-1:0] cur_period, cur_width;
    logic [CW-1:0] rem;

    logic hs, burst_end, load, advance, go_idle, done_d;
    logic wrap, pul_next;

    assign in_cmd    = '{period: cmd_period, width: cmd_width, count: cmd_count};
    assign cmd_ready = !rst && !pend_full && !abort;
    assign hs        = cmd_valid && cmd_ready;
    assign burst_end = (state == RUN) && wrap && (rem == CW'(1));

    always_comb begin
        ld_cmd  = in_cmd;
        load    = 1'b0;
        advance = 1'b0;
        go_idle = 1'b0;
        done_d  = 1'b0;
        if (state == IDLE) begin
            // A zero-count command is acknowledged with done but never runs.
            if (hs) begin
                load   = (in_cmd.count != '0);
                done_d = (in_cmd.count == '0);
            end
        end else if (burst_end) begin
            done_d = 1'b1;
            if (pend_full) begin
                ld_cmd = pend;
                load   = (pend.count != '0);
            end else if (hs) begin
                load   = (in_cmd.count != '0);
            end
            go_idle = !load;
        end else begin
            advance = 1'b1;
        end
    end

    pulse_phase_cnt #(.PW(PW)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort || go_idle),
        .load     (load),
        .advance  (advance),
        .period   (cur_period),
        .width    (load ? ld_cmd.width : cur_width),
        .wrap     (wrap),
        .pul_next (pul_next)
    );

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state      <= IDLE;
            pend_full  <= 1'b0;
            pend       <= '0;
            cur_period <= '0;
            cur_width  <= '0;
            rem        <= '0;
            pul_out    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_d;
            if (load) begin
                state      <= RUN;
                cur_period <= ld_cmd.period;
                cur_width  <= ld_cmd.width;
                rem        <= ld_cmd.count;
                pul_out    <= pul_next;
            end else if (go_idle) begin
                state   <= IDLE;
                rem     <= '0;
                pul_out <= 1'b0;
            end else if (advance) begin
                pul_out <= pul_next;
                if (wrap)
                    rem <= rem - CW'(1);
            end

            // Pending slot empties at every burst end; a zero-count entry is simply dropped.
            if (burst_end)
                pend_full <= 1'b0;
            else if (state == RUN && hs) begin
                pend      <= in_cmd;
                pend_full <= 1'b1;
            end
        end
    end

    assign busy        = (state == RUN);
    assign pulses_left = rem;
endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Scoreboard bench for pulse_burst_ctrl: per-cycle expectations queued at stimulus time.
module tb_pulse_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_period = '0, cmd_width = '0, cmd_count = '0;
    logic        abort = 1'b0;
    logic        pul_out, busy, done;
    logic [15:0] pulses_left;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit pul;
        bit busy;
        bit done;
        int left;
    } exp_t;
    exp_t sb[$];

    pulse_burst_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_period  (cmd_period),
        .cmd_width   (cmd_width),
        .cmd_count   (cmd_count),
        .abort       (abort),
        .pul_out     (pul_out),
        .busy        (busy),
        .done        (done),
        .pulses_left (pulses_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input bit pul, input bit bsy, input bit dn, input int left);
        exp_t e;
        e.pul = pul; e.busy = bsy; e.done = dn; e.left = left;
        sb.push_back(e);
    endtask

    task automatic push_idle(input bit dn);
        push(1'b0, 1'b0, dn, 0);
    endtask

    // Expected waveform of a whole burst; done flag marks its first cycle.
    task automatic push_burst(input int p, input int w, input int c, input bit first_done);
        int pe;
        pe = (p == 0) ? 1 : p;
        for (int k = 0; k < c; k++)
            for (int ph = 0; ph < pe; ph++)
                push(ph < w, 1'b1, first_done && k == 0 && ph == 0, c - k);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pul_out", pul_out, e.pul);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("pulses_left", pulses_left, e.left);
        end
    endtask

    task automatic drive(input int p, input int w, input int c);
        cmd_valid  = 1'b1;
        cmd_period = p[15:0];
        cmd_width  = w[15:0];
        cmd_count  = c[15:0];
    endtask

    task automatic send(input int p, input int w, input int c);
        chk("ready_before_send", cmd_ready, 1'b1);
        drive(p, w, c);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 500) begin
            tick();
            guard++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_pul", pul_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_left", pulses_left, 0);
        chk("ready_after_rst", cmd_ready, 1'b1);

        // basic burst 1100 x3
        push_burst(4, 2, 3, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        push_idle(1'b0);
        send(4, 2, 3);
        drain();

        // back-to-back via pending slot: 1000 1000 111
        push_burst(4, 1, 2, 1'b0);
        push_burst(3, 3, 1, 1'b1);
        push_idle(1'b1);
        push_idle(1'b0);
        send(4, 1, 2);
        drive(3, 3, 1);
        tick();
        cmd_valid = 1'b0;
        for (int n = 3; n <= 9; n++) begin
            chk("ready_pending", cmd_ready, 1'b0);
            tick();
        end
        chk("ready_after_load", cmd_ready, 1'b1);
        drain();

        // period 0 and width >= period
        push_burst(0, 0, 5, 1'b0);
        push_idle(1'b1);
        send(0, 0, 5);
        drain();
        push_burst(5, 7, 1, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        send(5, 7, 1);
        drain();

        // abort at 3rd cycle of period 2 with a pending command
        for (int i = 0; i < 11; i++)
            push(i % 8 < 4, 1'b1, 1'b0, 10 - i / 8);
        send(8, 4, 10);
        drive(2, 2, 2);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++)
            tick();
        abort = 1'b1;
        drive(3, 1, 1);
        #1;
        chk("ready_abort", cmd_ready, 1'b0);
        push_idle(1'b0);
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b0);
        drain();

        // count 0 in IDLE, then queued behind a burst
        push_idle(1'b1);
        push_idle(1'b0);
        send(3, 1, 0);
        drain();
        push_burst(2, 1, 1, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        push_idle(1'b0);
        send(2, 1, 1);
        drive(3, 1, 0);
        tick();
        cmd_valid = 1'b0;
        drain();

        // rst mid-burst with a command held on the bus
        for (int i = 0; i < 5; i++)
            push(i % 4 < 2, 1'b1, 1'b0, 3 - i / 4);
        send(4, 2, 3);
        for (int i = 0; i < 4; i++)
            tick();
        rst = 1'b1;
        drive(2, 1, 1);
        #1;
        chk("ready_in_rst", cmd_ready, 1'b0);
        push_idle(1'b0);
        push_idle(1'b0);
        tick(); tick();
        rst = 1'b0;
        push_burst(2, 1, 1, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        tick();
        cmd_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
